// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// word-offset geometry.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WORD_OFFSET_BITS = 2;

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    // Reserved size 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [WORD_OFFSET_BITS-1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != '0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane steering: extracts and extends load data from a DM word and
// merges sub-word store data into a DM word for the read-modify-write path.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0]                 word,
    input  logic [WORD_OFFSET_BITS-1:0] offset,
    input  logic [1:0]                  size,
    input  logic                        zero_ext,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 load_data,
    output logic [31:0]                 merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (size)
            SZ_BYTE: load_data = zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: load_data = zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]       = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word CPU accesses into word DM accesses,
// with a 2-cycle read-modify-write for sub-word stores and misalign capture.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [1:0]        cpu_size_i,
    input  logic              cpu_unsigned_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              err_sticky_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [CNT_W-1:0]  rmw_count_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    output logic              dm_write_o,
    output logic              dm_read_o,
    input  logic [31:0]       dm_rdata_i
);

    state_t                      state_q, state_d;
    logic [31:0]                 merge_q;
    logic                        merge_load;
    logic                        rmw_done;
    logic                        err_sticky_q;
    logic [ADDR_W-1:0]           err_addr_q;
    logic [CNT_W-1:0]            rmw_count_q;

    logic [1:0]                  size;
    logic [WORD_OFFSET_BITS-1:0] offset;
    logic                        req;
    logic                        sub_word;
    logic                        misalign;
    logic [31:0]                 load_data;
    logic [31:0]                 merged;

    assign size     = norm_size(cpu_size_i);
    assign offset   = cpu_addr_i[WORD_OFFSET_BITS-1:0];
    assign req      = cpu_read_i | cpu_write_i;
    assign sub_word = (size != SZ_WORD);
    assign misalign = req & is_misaligned(size, offset);

    mem_lane_align u_align (
        .word      (dm_rdata_i),
        .offset    (offset),
        .size      (size),
        .zero_ext  (cpu_unsigned_i),
        .wdata     (cpu_wdata_i),
        .load_data (load_data),
        .merged    (merged)
    );

    // The DM address is always the word-aligned CPU address; during RMW_WR the
    // CPU is holding the same request, so no separate address register is needed.
    assign dm_addr_o = {cpu_addr_i[ADDR_W-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};

    always_comb begin
        state_d     = state_q;
        merge_load  = 1'b0;
        rmw_done    = 1'b0;
        stall_o     = 1'b0;
        dm_read_o   = 1'b0;
        dm_write_o  = 1'b0;
        dm_wdata_o  = cpu_wdata_i;
        cpu_rdata_o = 32'h0;
        case (state_q)
            IDLE: begin
                if (!misalign) begin
                    // A store takes priority over a simultaneous load.
                    if (cpu_write_i) begin
                        if (sub_word) begin
                            dm_read_o  = 1'b1;
                            stall_o    = rst_n;
                            merge_load = 1'b1;
                            state_d    = RMW_WR;
                        end else begin
                            dm_write_o = rst_n;
                        end
                    end else if (cpu_read_i) begin
                        dm_read_o   = 1'b1;
                        cpu_rdata_o = load_data;
                    end
                end
            end
            RMW_WR: begin
                dm_write_o = rst_n;
                dm_wdata_o = merge_q;
                rmw_done   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            merge_q      <= 32'h0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
            rmw_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (merge_load)
                merge_q <= merged;
            if (rmw_done && (rmw_count_q != {CNT_W{1'b1}}))
                rmw_count_q <= rmw_count_q + CNT_W'(1);
            if (misalign && !err_sticky_q) begin
                err_sticky_q <= 1'b1;
                err_addr_q   <= cpu_addr_i;
            end
        end
    end

    assign misalign_o   = misalign;
    assign err_sticky_o = err_sticky_q;
    assign err_addr_o   = err_addr_q;
    assign rmw_count_o  = rmw_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, directed RMW/misalign/reset/saturation
// sequences, and random traffic checked against a byte-array memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic        cpu_read_i, cpu_write_i, cpu_unsigned_i;
    logic [1:0]  cpu_size_i;
    logic [31:0] cpu_rdata_o;
    logic        stall_o, misalign_o, err_sticky_o;
    logic [31:0] err_addr_o;
    logic [1:0]  rmw_count_o;
    logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i;
    logic        dm_write_o, dm_read_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:63];
    logic [7:0]  rb  [0:255];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i),
        .cpu_size_i(cpu_size_i), .cpu_unsigned_i(cpu_unsigned_i),
        .cpu_rdata_o(cpu_rdata_o), .stall_o(stall_o), .misalign_o(misalign_o),
        .err_sticky_o(err_sticky_o), .err_addr_o(err_addr_o),
        .rmw_count_o(rmw_count_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_write_o(dm_write_o), .dm_read_o(dm_read_o), .dm_rdata_i(dm_rdata_i)
    );

    // Data memory: combinational read, write on the rising edge.
    assign dm_rdata_i = mem[dm_addr_o[7:2]];
    always @(posedge clk) if (dm_write_o) mem[dm_addr_o[7:2]] <= dm_wdata_o;

    typedef struct {
        logic rd; logic wr; logic [1:0] sz; logic uns;
        logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] e_rdata; logic e_stall; logic e_mis; logic e_dmw; logic e_dmr;
        logic [31:0] e_dmaddr;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        cpu_read_i = rd; cpu_write_i = wr; cpu_size_i = sz;
        cpu_unsigned_i = uns; cpu_addr_i = a; cpu_wdata_i = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] ref_load(input int a, input int n, input logic uns);
        logic [31:0] v, mask;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(rb[a+i]) << (8*i));
        mask = (n == 4) ? 32'hFFFFFFFF : ((32'h1 << (8*n)) - 32'h1);
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        for (int w = 0; w < 64; w++) mem[w] = 32'h0;
        mem[8] = 32'h80FF7F01;

        //           rd  wr  sz     uns  addr   wdata         rdata        st mis dmw dmr dm_addr
        vecs[0]  = '{1'b0,1'b1,2'b10,1'b0,32'h10,32'hDEADBEEF,32'h0,       1'b0,1'b0,1'b1,1'b0,32'h10};
        vecs[1]  = '{1'b1,1'b0,2'b10,1'b0,32'h10,32'h0,       32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,32'h10};
        vecs[2]  = '{1'b1,1'b0,2'b00,1'b0,32'h22,32'h0,       32'hFFFFFFFF,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[3]  = '{1'b1,1'b0,2'b00,1'b1,32'h23,32'h0,       32'h00000080,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[4]  = '{1'b1,1'b0,2'b01,1'b0,32'h22,32'h0,       32'hFFFF80FF,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[5]  = '{1'b1,1'b0,2'b01,1'b1,32'h20,32'h0,       32'h00007F01,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[6]  = '{1'b1,1'b0,2'b00,1'b0,32'h21,32'h0,       32'h0000007F,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[7]  = '{1'b1,1'b0,2'b00,1'b1,32'h20,32'h0,       32'h00000001,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[8]  = '{1'b1,1'b0,2'b11,1'b0,32'h20,32'h0,       32'h80FF7F01,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[9]  = '{1'b0,1'b0,2'b01,1'b0,32'h33,32'h0,       32'h0,       1'b0,1'b0,1'b0,1'b0,32'h30};
        vecs[10] = '{1'b1,1'b1,2'b10,1'b0,32'h24,32'h12345678,32'h0,       1'b0,1'b0,1'b1,1'b0,32'h24};
        vecs[11] = '{1'b1,1'b0,2'b10,1'b0,32'h24,32'h0,       32'h12345678,1'b0,1'b0,1'b0,1'b1,32'h24};
        vecs[12] = '{1'b1,1'b0,2'b01,1'b0,32'h20,32'h0,       32'h00007F01,1'b0,1'b0,1'b0,1'b1,32'h20};
        vecs[13] = '{1'b1,1'b0,2'b00,1'b0,32'h23,32'h0,       32'hFFFFFF80,1'b0,1'b0,1'b0,1'b1,32'h20};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("reset stall", 32'(stall_o), 32'h0);
        chk("reset sticky", 32'(err_sticky_o), 32'h0);
        chk("reset err_addr", err_addr_o, 32'h0);
        chk("reset count", 32'(rmw_count_o), 32'h0);
        chk("reset dm_write", 32'(dm_write_o), 32'h0);

        // Single-cycle vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d rdata", i), cpu_rdata_o, vecs[i].e_rdata);
            chk($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d misalign", i), 32'(misalign_o), 32'(vecs[i].e_mis));
            chk($sformatf("vec%0d dm_write", i), 32'(dm_write_o), 32'(vecs[i].e_dmw));
            chk($sformatf("vec%0d dm_read", i), 32'(dm_read_o), 32'(vecs[i].e_dmr));
            chk($sformatf("vec%0d dm_addr", i), dm_addr_o, vecs[i].e_dmaddr);
        end

        // Byte store RMW
        @(negedge clk); mem[4] = 32'h11223344;
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA); #1;
        chk("sb c1 stall", 32'(stall_o), 32'h1);
        chk("sb c1 dm_read", 32'(dm_read_o), 32'h1);
        chk("sb c1 dm_write", 32'(dm_write_o), 32'h0);
        @(negedge clk); #1;
        chk("sb c2 stall", 32'(stall_o), 32'h0);
        chk("sb c2 dm_write", 32'(dm_write_o), 32'h1);
        chk("sb c2 wdata", dm_wdata_o, 32'h11AA3344);
        @(negedge clk); idle(); #1;
        chk("sb count", 32'(rmw_count_o), 32'h1);
        chk("sb mem", mem[4], 32'h11AA3344);

        // Misalignment and first-address capture
        @(negedge clk); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h31, 32'h0); #1;
        chk("lw mis", 32'(misalign_o), 32'h1);
        chk("lw mis enables", {30'h0, dm_read_o, dm_write_o}, 32'h0);
        chk("lw mis rdata", cpu_rdata_o, 32'h0);
        @(negedge clk); drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h45, 32'h1234); #1;
        chk("sh mis", 32'(misalign_o), 32'h1);
        chk("sh mis enables", {30'h0, dm_read_o, dm_write_o}, 32'h0);
        chk("sh mis stall", 32'(stall_o), 32'h0);
        @(negedge clk); idle(); #1;
        chk("sticky", 32'(err_sticky_o), 32'h1);
        chk("err_addr first", err_addr_o, 32'h31);

        // Reset during RMW_WR
        @(negedge clk); mem[20] = 32'hCAFEF00D;
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h50, 32'h0000BEEF); #1;
        chk("rst-rmw c1 stall", 32'(stall_o), 32'h1);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst-rmw no write", 32'(dm_write_o), 32'h0);
        @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0); #1;
        chk("rst-rmw mem kept", mem[20], 32'hCAFEF00D);
        chk("rst-rmw count", 32'(rmw_count_o), 32'h0);
        chk("rst-rmw sticky", 32'(err_sticky_o), 32'h0);
        chk("rst-rmw idle load", cpu_rdata_o, 32'hCAFEF00D);

        // Counter saturation: five back-to-back byte stores
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 2'b00, 1'b0, 32'(4*k + 1), 32'(k)); #1;
            chk($sformatf("sat%0d stall c1", k), 32'(stall_o), 32'h1);
            if (k > 0) chk($sformatf("sat%0d count", k), 32'(rmw_count_o), 32'((k > 3) ? 3 : k));
            @(negedge clk); #1;
            chk($sformatf("sat%0d stall c2", k), 32'(stall_o), 32'h0);
            chk($sformatf("sat%0d dm_write", k), 32'(dm_write_o), 32'h1);
        end
        @(negedge clk); idle(); #1;
        chk("sat final count", 32'(rmw_count_o), 32'h3);

        // Random traffic vs byte-array model
        begin
            logic        first_seen;
            logic [31:0] first_addr;
            first_seen = 1'b0;
            first_addr = 32'h0;
            @(negedge clk);
            rst_n = 1'b0;
            for (int w = 0; w < 64; w++) begin
                mem[w] = $urandom;
                for (int b = 0; b < 4; b++) rb[4*w+b] = mem[w][8*b +: 8];
            end
            @(negedge clk); rst_n = 1'b1;
            for (int t = 0; t < 300; t++) begin
                int kind, n, a;
                logic [1:0]  sz;
                logic        uns, rd, mis;
                logic [31:0] d;
                kind = $urandom_range(0, 2);
                sz   = 2'($urandom_range(0, 3));
                n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
                a    = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) a = a - (a % n);
                uns  = 1'($urandom_range(0, 1));
                d    = $urandom;
                rd   = (kind == 0) ? 1'b1 : (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                mis  = (kind != 2) && ((a % n) != 0);
                @(negedge clk);
                drive(rd, kind == 1, sz, uns, 32'(a), d); #1;
                chk("rnd misalign", 32'(misalign_o), 32'(mis));
                if (mis) begin
                    chk("rnd mis enables", {30'h0, dm_read_o, dm_write_o}, 32'h0);
                    if (!first_seen) begin first_seen = 1'b1; first_addr = 32'(a); end
                end else if (kind == 1) begin
                    if (n < 4) begin
                        chk("rnd rmw stall", 32'(stall_o), 32'h1);
                        @(negedge clk); #1;
                        chk("rnd rmw write", 32'(dm_write_o), 32'h1);
                        chk("rnd rmw stall2", 32'(stall_o), 32'h0);
                    end else begin
                        chk("rnd sw stall", 32'(stall_o), 32'h0);
                        chk("rnd sw write", 32'(dm_write_o), 32'h1);
                    end
                    for (int b = 0; b < n; b++) rb[a+b] = d[8*b +: 8];
                end else if (kind == 0) begin
                    chk("rnd load", cpu_rdata_o, ref_load(a, n, uns));
                end else begin
                    chk("rnd idle enables", {30'h0, dm_read_o, dm_write_o}, 32'h0);
                end
            end
            @(negedge clk); idle(); #1;
            for (int w = 0; w < 64; w++)
                chk($sformatf("rnd mem[%0d]", w), mem[w],
                    {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]});
            chk("rnd sticky", 32'(err_sticky_o), 32'(first_seen));
            chk("rnd err_addr", err_addr_o, first_addr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
